// File: rtl/dpram_param.sv
// True dual-port RAM with byte-lane writes, read-first ports, optional output register and a post-reset zero-fill engine.
// Port A wins byte lanes on same-address write/write conflicts; collision flags any same-address access involving a write.
module dpram_param #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 6,
  parameter int DEPTH          = 64,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  a_cs,
  input  logic                  a_we,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_cs,
  input  logic                  b_we,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  b_rvalid,
  output logic                  init_busy,
  output logic                  collision
);

  localparam int                NB        = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                act, a_in, b_in, a_wr, b_wr;
  logic                rd_req [2];
  logic [DATA_W-1:0]   word [2];
  logic                s1_vld_q [2], s1_vld_d [2];
  logic [DATA_W-1:0]   s1_dat_q [2], s1_dat_d [2];
  logic                collision_q, collision_d;

  // Clear engine: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Clear engine: next state
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = ST_READY;
        clr_cnt_d = '0;
      end
    end
  end

  // Clear engine: outputs
  always_comb begin
    init_busy = (state_q == ST_CLEAR);
  end

  always_comb begin
    act         = (state_q == ST_READY) && en;
    a_in        = ({1'b0, a_addr} < DEPTH_L);
    b_in        = ({1'b0, b_addr} < DEPTH_L);
    a_wr        = act && a_cs && a_we && a_in;
    b_wr        = act && b_cs && b_we && b_in;
    rd_req[0]   = act && a_cs && !a_we;
    rd_req[1]   = act && b_cs && !b_we;
    word[0]     = a_in ? mem_q[a_addr] : '0;
    word[1]     = b_in ? mem_q[b_addr] : '0;
    collision_d = act && a_cs && b_cs && (a_addr == b_addr) && (a_we || b_we);
    for (int p = 0; p < 2; p++) begin
      s1_vld_d[p] = rd_req[p];
      s1_dat_d[p] = !en ? '0 : (rd_req[p] ? word[p] : s1_dat_q[p]);
    end
  end

  // Port A's lane writes are issued last so they override B on overlapping lanes.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (b_wr && b_be[i]) mem_q[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        if (a_wr && a_be[i]) mem_q[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        s1_vld_q[p] <= 1'b0;
        s1_dat_q[p] <= '0;
      end
    end else begin
      collision_q <= collision_d;
      for (int p = 0; p < 2; p++) begin
        s1_vld_q[p] <= s1_vld_d[p];
        s1_dat_q[p] <= s1_dat_d[p];
      end
    end
  end

  assign collision = collision_q;

  if (OUT_REG != 0) begin : g_oreg
    logic              s2_vld_q [2], s2_vld_d [2];
    logic [DATA_W-1:0] s2_dat_q [2], s2_dat_d [2];

    always_comb begin
      for (int p = 0; p < 2; p++) begin
        s2_vld_d[p] = en && s1_vld_q[p];
        s2_dat_d[p] = !en ? '0 : (s1_vld_q[p] ? s1_dat_q[p] : s2_dat_q[p]);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int p = 0; p < 2; p++) begin
          s2_vld_q[p] <= 1'b0;
          s2_dat_q[p] <= '0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          s2_vld_q[p] <= s2_vld_d[p];
          s2_dat_q[p] <= s2_dat_d[p];
        end
      end
    end

    assign a_rdata  = s2_dat_q[0];
    assign a_rvalid = s2_vld_q[0];
    assign b_rdata  = s2_dat_q[1];
    assign b_rvalid = s2_vld_q[1];
  end else begin : g_noreg
    assign a_rdata  = s1_dat_q[0];
    assign a_rvalid = s1_vld_q[0];
    assign b_rdata  = s1_dat_q[1];
    assign b_rvalid = s1_vld_q[1];
  end

endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: latency-1 and latency-2 instances share stimulus and are checked against an array-based model.
module tb_dpram_param;

  localparam int DW    = 64;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en;
  logic          a_cs, a_we, b_cs, b_we;
  logic [NB-1:0] a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  // [dut][port]; dut 0 has OUT_REG=0, dut 1 has OUT_REG=1
  logic [DW-1:0] rd [2][2];
  logic          rv [2][2];
  logic          busy [2];
  logic          col [2];

  always #5 clk = ~clk;

  dpram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(rd[0][0]), .a_rvalid(rv[0][0]),
    .b_cs(b_cs), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(rd[0][1]), .b_rvalid(rv[0][1]),
    .init_busy(busy[0]), .collision(col[0]));

  dpram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(rd[1][0]), .a_rvalid(rv[1][0]),
    .b_cs(b_cs), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(rd[1][1]), .b_rvalid(rv[1][1]),
    .init_busy(busy[1]), .collision(col[1]));

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  int            clr_n;
  logic          h_vld [2][2];
  logic [DW-1:0] h_dat [2][2];
  logic [DW-1:0] exp_rd [2][2];
  logic          exp_rv [2][2];
  logic          exp_col, exp_busy;

  int n_vec = 0;
  int n_err = 0;

  task automatic idle();
    en = 1'b1; a_cs = 1'b0; a_we = 1'b0; b_cs = 1'b0; b_we = 1'b0;
    a_be = '0; b_be = '0; a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    clr_n = 0; exp_busy = 1'b1; exp_col = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        h_vld[d][p] = 1'b0; h_dat[d][p] = '0; exp_rd[d][p] = '0; exp_rv[d][p] = 1'b0;
      end
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply current inputs for one clock edge and advance the model; returns at the next falling edge.
  task automatic step();
    logic          bsy;
    logic          req [2];
    logic [DW-1:0] w [2];
    bsy    = (clr_n < DEPTH);
    req[0] = !bsy && en && a_cs && !a_we;
    req[1] = !bsy && en && b_cs && !b_we;
    w[0]   = ref_mem[a_addr];
    w[1]   = ref_mem[b_addr];
    exp_col = !bsy && en && a_cs && b_cs && (a_addr == b_addr) && (a_we || b_we);
    if (!bsy && en) begin
      for (int i = 0; i < NB; i++)
        if (b_cs && b_we && b_be[i]) ref_mem[b_addr][8*i +: 8] = b_wdata[8*i +: 8];
      for (int i = 0; i < NB; i++)
        if (a_cs && a_we && a_be[i]) ref_mem[a_addr][8*i +: 8] = a_wdata[8*i +: 8];
    end
    if (clr_n < DEPTH) begin
      clr_n++;
      if (clr_n == DEPTH) foreach (ref_mem[k]) ref_mem[k] = '0;
    end
    exp_busy = (clr_n < DEPTH);
    for (int p = 0; p < 2; p++) begin
      h_vld[p][1] = h_vld[p][0]; h_dat[p][1] = h_dat[p][0];
      h_vld[p][0] = req[p];      h_dat[p][0] = w[p];
      for (int d = 0; d < 2; d++) begin
        if (!en) begin
          exp_rv[d][p] = 1'b0; exp_rd[d][p] = '0;
        end else if (h_vld[p][d]) begin
          exp_rv[d][p] = 1'b1; exp_rd[d][p] = h_dat[p][d];
        end else begin
          exp_rv[d][p] = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    idle();
    do_reset(3);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        n_vec++;
        if (rd[d][p] !== '0 || rv[d][p] !== 1'b0) begin
          n_err++; $display("FAIL reset_out d%0d p%0d: rdata=%h rvalid=%b, need 0/0", d, p, rd[d][p], rv[d][p]);
        end
      end
      n_vec++;
      if (busy[d] !== 1'b1 || col[d] !== 1'b0) begin
        n_err++; $display("FAIL reset_flags d%0d: init_busy=%b collision=%b, need 1/0", d, busy[d], col[d]);
      end
    end
    a_cs = 1'b1; a_we = 1'b0; a_addr = AW'($urandom_range(0, DEPTH-1));
    b_cs = 1'b1; b_we = 1'b1; b_addr = AW'(DEPTH-1); b_be = '1; b_wdata = '1;
    n = 0;
    while (busy[0] === 1'b1 && n < 200) begin
      step();
      n++;
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (rv[d][0] !== 1'b0 || col[d] !== 1'b0) begin
          n_err++; $display("FAIL busy_quiet d%0d cyc%0d: rvalid=%b collision=%b, need 0/0", d, n, rv[d][0], col[d]);
        end
      end
    end
    n_vec++;
    if (n != DEPTH || busy[1] !== 1'b0) begin
      n_err++; $display("FAIL clear_len: busy cycles=%0d u1_busy=%b, need %0d/0", n, busy[1], DEPTH);
    end
    idle(); a_cs = 1'b1; a_addr = AW'(DEPTH-1);
    step(); idle();
    n_vec++;
    if (rv[0][0] !== 1'b1 || rd[0][0] !== '0) begin
      n_err++; $display("FAIL read_last_l1: rvalid=%b rdata=%h, need 1/0", rv[0][0], rd[0][0]);
    end
    step();
    n_vec++;
    if (rv[1][0] !== 1'b1 || rd[1][0] !== '0) begin
      n_err++; $display("FAIL read_last_l2: rvalid=%b rdata=%h, need 1/0", rv[1][0], rd[1][0]);
    end
  endtask

  task automatic test_byte_enables();
    logic [DW-1:0] want;
    want = 64'h01234567FFFFFFFF;
    idle(); a_cs = 1'b1; a_we = 1'b1; a_addr = 6'd5; a_be = 8'hFF; a_wdata = 64'h0123456789ABCDEF;
    step();
    a_be = 8'h0F; a_wdata = 64'hFFFFFFFFFFFFFFFF;
    step();
    idle(); b_cs = 1'b1; b_addr = 6'd5;
    step(); idle();
    n_vec++;
    if (rv[0][1] !== 1'b1 || rd[0][1] !== want || rv[1][1] !== 1'b0) begin
      n_err++; $display("FAIL be_l1: rvalid=%b rdata=%h l2_rvalid=%b, need 1/%h/0", rv[0][1], rd[0][1], rv[1][1], want);
    end
    step();
    n_vec++;
    if (rv[1][1] !== 1'b1 || rd[1][1] !== want || rv[0][1] !== 1'b0) begin
      n_err++; $display("FAIL be_l2: rvalid=%b rdata=%h l1_rvalid=%b, need 1/%h/0", rv[1][1], rd[1][1], rv[0][1], want);
    end
  endtask

  task automatic test_ww_collision();
    logic [DW-1:0] want;
    want = 64'hAAAAAAAABBBB7788;
    idle(); a_cs = 1'b1; a_we = 1'b1; a_addr = 6'd9; a_be = 8'hFF; a_wdata = 64'h1122334455667788;
    step();
    a_be = 8'hF0; a_wdata = 64'hAAAAAAAAAAAAAAAA;
    b_cs = 1'b1; b_we = 1'b1; b_addr = 6'd9; b_be = 8'h3C; b_wdata = 64'hBBBBBBBBBBBBBBBB;
    step(); idle();
    n_vec++;
    if (col[0] !== 1'b1 || col[1] !== 1'b1) begin
      n_err++; $display("FAIL ww_col_pulse: collision=%b/%b, need 1/1", col[0], col[1]);
    end
    a_cs = 1'b1; a_addr = 6'd9;
    step(); idle();
    n_vec++;
    if (col[0] !== 1'b0 || rd[0][0] !== want) begin
      n_err++; $display("FAIL ww_word: collision=%b rdata=%h, need 0/%h", col[0], rd[0][0], want);
    end
    step();
    n_vec++;
    if (rd[1][0] !== want) begin
      n_err++; $display("FAIL ww_word_l2: rdata=%h, need %h", rd[1][0], want);
    end
  endtask

  task automatic test_rw_collision();
    idle(); a_cs = 1'b1; a_we = 1'b1; a_addr = 6'd2; a_be = 8'hFF; a_wdata = 64'h11;
    step();
    a_wdata = 64'h22; b_cs = 1'b1; b_addr = 6'd2;
    step(); idle(); b_cs = 1'b1; b_addr = 6'd2;
    n_vec++;
    if (rv[0][1] !== 1'b1 || rd[0][1] !== 64'h11 || col[0] !== 1'b1) begin
      n_err++; $display("FAIL rw_old: rvalid=%b rdata=%h collision=%b, need 1/11/1", rv[0][1], rd[0][1], col[0]);
    end
    step(); idle();
    n_vec++;
    if (rd[1][1] !== 64'h11 || rd[0][1] !== 64'h22 || col[1] !== 1'b0) begin
      n_err++; $display("FAIL rw_next: l2=%h l1=%h collision=%b, need 11/22/0", rd[1][1], rd[0][1], col[1]);
    end
    step();
    n_vec++;
    if (rv[1][1] !== 1'b1 || rd[1][1] !== 64'h22) begin
      n_err++; $display("FAIL rw_next_l2: rvalid=%b rdata=%h, need 1/22", rv[1][1], rd[1][1]);
    end
  endtask

  task automatic test_en_low();
    idle(); a_cs = 1'b1; a_we = 1'b1; a_addr = 6'd7; a_be = 8'hFF; a_wdata = 64'hCAFEF00D12345678;
    step();
    a_we = 1'b0;
    step();
    en = 1'b0; a_we = 1'b1; a_wdata = 64'hDEADBEEFDEADBEEF;
    step();
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (rv[d][0] !== 1'b0 || rd[d][0] !== '0) begin
        n_err++; $display("FAIL en_low_drop d%0d: rvalid=%b rdata=%h, need 0/0", d, rv[d][0], rd[d][0]);
      end
    end
    idle(); a_cs = 1'b1; a_addr = 6'd7;
    step(); idle();
    n_vec++;
    if (rd[0][0] !== 64'hCAFEF00D12345678) begin
      n_err++; $display("FAIL en_low_nowrite: rdata=%h, need cafef00d12345678", rd[0][0]);
    end
    step();
  endtask

  task automatic test_mid_clear_reset();
    int n;
    idle();
    do_reset(2);
    a_cs = 1'b1; a_addr = 6'd3;
    repeat (30) step();
    n_vec++;
    if (busy[0] !== 1'b1 || busy[1] !== 1'b1) begin
      n_err++; $display("FAIL midclear_busy: init_busy=%b/%b, need 1/1", busy[0], busy[1]);
    end
    do_reset(1);
    n = 0;
    while (busy[0] === 1'b1 && n < 200) begin
      step();
      n++;
    end
    n_vec++;
    if (n != DEPTH) begin
      n_err++; $display("FAIL midclear_len: busy cycles=%0d, need %0d", n, DEPTH);
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      en      = ($urandom_range(0, 9) != 0);
      a_cs    = $urandom_range(0, 1) != 0; a_we = $urandom_range(0, 1) != 0;
      b_cs    = $urandom_range(0, 1) != 0; b_we = $urandom_range(0, 1) != 0;
      a_be    = NB'($urandom); b_be = NB'($urandom);
      a_addr  = AW'($urandom_range(0, 7)); b_addr = AW'($urandom_range(0, 7));
      a_wdata = {$urandom, $urandom}; b_wdata = {$urandom, $urandom};
      step();
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          n_vec++;
          if (rv[d][p] !== exp_rv[d][p] || rd[d][p] !== exp_rd[d][p]) begin
            n_err++;
            $display("FAIL rand_read c%0d d%0d p%0d: rvalid=%b rdata=%h, need %b/%h", c, d, p, rv[d][p], rd[d][p], exp_rv[d][p], exp_rd[d][p]);
          end
        end
        n_vec++;
        if (col[d] !== exp_col || busy[d] !== exp_busy) begin
          n_err++; $display("FAIL rand_flags c%0d d%0d: collision=%b busy=%b, need %b/%b", c, d, col[d], busy[d], exp_col, exp_busy);
        end
      end
    end
    idle();
  endtask

  task automatic test_streaming();
    logic [DW-1:0] snap [DEPTH];
    foreach (snap[k]) snap[k] = ref_mem[k];
    idle();
    for (int i = 0; i <= DEPTH + 1; i++) begin
      a_cs   = (i < DEPTH);
      a_addr = AW'(i);
      b_cs   = $urandom_range(0, 1) != 0; b_we = 1'b0; b_addr = AW'($urandom_range(0, DEPTH-1));
      step();
      n_vec++;
      if (i < DEPTH ? (rv[0][0] !== 1'b1 || rd[0][0] !== snap[i]) : (rv[0][0] !== 1'b0)) begin
        n_err++; $display("FAIL stream_l1 i%0d: rvalid=%b rdata=%h", i, rv[0][0], rd[0][0]);
      end
      n_vec++;
      if (i == 0 || i > DEPTH) begin
        if (rv[1][0] !== 1'b0) begin
          n_err++; $display("FAIL stream_l2_gap i%0d: rvalid=%b, need 0", i, rv[1][0]);
        end
      end else if (rv[1][0] !== 1'b1 || rd[1][0] !== snap[i-1]) begin
        n_err++; $display("FAIL stream_l2 i%0d: rvalid=%b rdata=%h, need 1/%h", i, rv[1][0], rd[1][0], snap[i-1]);
      end
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    foreach (ref_mem[k]) ref_mem[k] = '0;
    idle();
    test_reset();
    test_byte_enables();
    test_ww_collision();
    test_rw_collision();
    test_en_low();
    test_mid_clear_reset();
    test_random();
    test_streaming();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dpram_param.md
Name: dpram_param

Overview:
- Parametrised true dual-port synchronous RAM; next generation of the accelerator's 64x64 key/data store.
- Adds the following:
  - Configurable width and depth.
  - Per-byte write enables.
  - Optional output pipeline register.
  - Read-valid strobes.
  - Deterministic same-address collision resolution.
  - Post-reset hardware clear engine, so that DES key/subkey storage never exposes stale data.
- Sits between the host load interface (port A) and the DES round engine (port B).

Parameters:
- DATA_W, 64, word width in bits; must be a multiple of 8.
- ADDR_W, 6, address width.
- DEPTH, 64, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- OUT_REG, 0, 0 gives read latency 1; 1 gives read latency 2 (extra output register).
- CLEAR_ON_RESET, 1, 1 zeroes all words after reset; 0 skips the clear.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable, active high.
- a_cs  in  1  port A access request.
- a_we  in  1  port A: 1 = write, 0 = read (valid only when a_cs=1).
- a_be  in  DATA_W/8  port A byte-lane write enables; bit i covers data[8i+7:8i].
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_rdata  out  DATA_W  port A read data.
- a_rvalid  out  1  port A read-data-valid pulse.
- b_cs, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid: identical set for port B.
- init_busy  out  1  clear engine running; all requests ignored.
- collision  out  1  one-cycle pulse on a same-address conflict.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - a_rdata, b_rdata, a_rvalid, b_rvalid, collision all go to 0.
  - Every pipeline stage is flushed.
  - init_busy = CLEAR_ON_RESET.
  - The clear counter goes to 0.
  - Array contents are not reset asynchronously.
- Clear state machine, states CLEAR and READY:
  - Out of reset, the FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - In CLEAR, one word per clk is written with all zeros, at addresses 0..DEPTH-1 in order. This takes exactly DEPTH cycles, regardless of en.
  - After the write to address DEPTH-1, the FSM goes to READY and init_busy falls on the same edge.
  - While init_busy=1, port requests perform no write, produce no rvalid, and do not raise collision.
  - Reset asserted mid-clear restarts the clear from address 0.
- en=0 (in READY):
  - No array write takes place.
  - On each clk, rdata and rvalid on both ports are driven to 0 and in-flight reads are dropped.
- Write (cs=1, we=1, en=1, READY):
  - At the clk edge, the bytes whose be bit is 1 are updated.
  - be=0 results in no change.
  - A write never produces rvalid.
- Read (cs=1, we=0, en=1, READY):
  - Latency 1 (OUT_REG=0): rdata is the addressed word and rvalid=1 in the cycle after the request.
  - Latency 2 (OUT_REG=1): the same, but two cycles after the request.
  - Back-to-back reads are fully pipelined, one per cycle per port.
  - rvalid is high for exactly one cycle per read.
  - rdata holds its last value when there is no read, unless en=0.
- Reads always return the pre-edge contents (read-first), on both ports, including during a same-cycle write.
- Out of range (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - A write is ignored.
  - A read returns 0 with rvalid=1.
- Collisions (both cs=1, same addr, READY, en=1):
  - Write/write: for lanes where both be bits are 1, port A's data wins. Each port's remaining enabled lanes are written normally. collision=1 in the next cycle.
  - Read/write: the reader gets the old word. collision=1 in the next cycle.
  - Read/read: both ports get the same word; collision stays 0.
- collision is registered: a one-cycle pulse per conflicting cycle, aligned with latency-1 timing.

Test Plan:
- Reset then clear:
  - Stimulus: DEPTH=64, CLEAR_ON_RESET=1; hold rst_n low 3 cycles, release.
  - Response: init_busy stays 1 for exactly 64 cycles. A request issued during that window gives no rvalid. Afterwards, a read of addr 63 returns 0 with rvalid=1.
- Byte enables:
  - Stimulus: write 64'h0123456789ABCDEF to addr 5 (be=FF), then write 64'hFFFFFFFFFFFFFFFF to addr 5 with be=0F, then read port B.
  - Response: b_rdata=64'h01234567FFFFFFFF, b_rvalid 1 cycle after the read (2 cycles with OUT_REG=1).
- Write/write collision:
  - Stimulus: A writes 64'hAAAA... with be=F0; B writes 64'hBBBB... with be=3C; both to addr 9.
  - Response: the word reads back 64'hAAAAAAAABBBB????. Lanes 7:4 come from A, lanes 3:2 from B, and lanes 1:0 keep the old value. collision pulses 1 cycle.
- Read/write collision:
  - Stimulus: addr 2 holds 64'h11; in one cycle, A writes 64'h22 to addr 2 while B reads addr 2.
  - Response: b_rdata=64'h11 and collision=1. The next B read returns 64'h22.
- en low and mid-clear reset:
  - Stimulus: issue a read, then drop en in the following cycle.
  - Response: rdata=0 and rvalid=0 (the read is dropped), and no write occurs.
  - Stimulus: pulse rst_n low at clear address 30.
  - Response: the clear restarts and init_busy lasts the full 64 cycles.
- Streaming:
  - Stimulus: OUT_REG=1; A issues 64 consecutive reads, addr 0..63.
  - Response: rvalid is high for 64 consecutive cycles starting at cycle 2, with the data in address order.
